// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared state encoding and oversampling constants for the UART.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_NB_STATE         = 2;
    localparam int c_OVERSAMPLE       = 16;
    localparam int c_MID_BIT          = 7;
    localparam int c_BAUD_DIV_DEFAULT = 326;

    typedef enum logic [c_NB_STATE-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Brief    : Free-running divider producing the 16x oversampling tick.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = c_BAUD_DIV_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int                 c_CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BAUD_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = (r_cnt_q == c_LAST) ? '0 : r_cnt_q + c_CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_tick = (r_cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 receiver, samples each bit at its middle using the 16x tick.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tick,
    output logic               o_rx_done_tick,
    output logic [NB_DATA-1:0] o_rx
);

    localparam int                  c_NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [3:0]          c_S_MID  = 4'(c_MID_BIT);
    localparam logic [3:0]          c_S_LAST = 4'(c_OVERSAMPLE - 1);
    localparam logic [3:0]          c_S_STOP = 4'(SB_TICK - 1);
    localparam logic [c_NB_CNT-1:0] c_N_LAST = c_NB_CNT'(NB_DATA - 1);

    logic [1:0]          r_sync_q,  w_sync_d;
    uart_state_e         r_state_q, w_state_d;
    logic [3:0]          r_s_q,     w_s_d;
    logic [c_NB_CNT-1:0] r_n_q,     w_n_d;
    logic [NB_DATA-1:0]  r_b_q,     w_b_d;
    logic [NB_DATA-1:0]  r_data_q,  w_data_d;
    logic                r_done_q,  w_done_d;
    logic                w_line;

    assign w_line = r_sync_q[1];

    always_comb begin
        w_sync_d  = {r_sync_q[0], i_rx};
        w_state_d = r_state_q;
        w_s_d     = r_s_q;
        w_n_d     = r_n_q;
        w_b_d     = r_b_q;
        w_data_d  = r_data_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (!w_line) begin
                    w_state_d = START;
                    w_s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_s_q == c_S_MID) begin
                        // A start bit that is high again at its middle was a glitch.
                        if (!w_line) begin
                            w_state_d = DATA;
                            w_s_d     = '0;
                            w_n_d     = '0;
                        end else begin
                            w_state_d = IDLE;
                        end
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_s_q == c_S_LAST) begin
                        w_s_d = '0;
                        w_b_d = {w_line, r_b_q[NB_DATA-1:1]};
                        if (r_n_q == c_N_LAST) begin
                            w_state_d = STOP;
                        end else begin
                            w_n_d = r_n_q + c_NB_CNT'(1);
                        end
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_s_q == c_S_STOP) begin
                        w_data_d  = r_b_q;
                        w_done_d  = 1'b1;
                        w_state_d = IDLE;
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_q  <= 2'b11;
            r_state_q <= IDLE;
            r_s_q     <= '0;
            r_n_q     <= '0;
            r_b_q     <= '0;
            r_data_q  <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_state_q <= w_state_d;
            r_s_q     <= w_s_d;
            r_n_q     <= w_n_d;
            r_b_q     <= w_b_d;
            r_data_q  <= w_data_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_rx_done_tick = r_done_q;
    assign o_rx           = r_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Brief    : 8N1 transmitter with registered serial output.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx,
    output logic               o_tx,
    output logic               o_tx_done_tick
);

    localparam int                  c_NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [3:0]          c_S_LAST = 4'(c_OVERSAMPLE - 1);
    localparam logic [3:0]          c_S_STOP = 4'(SB_TICK - 1);
    localparam logic [c_NB_CNT-1:0] c_N_LAST = c_NB_CNT'(NB_DATA - 1);

    uart_state_e         r_state_q, w_state_d;
    logic [3:0]          r_s_q,     w_s_d;
    logic [c_NB_CNT-1:0] r_n_q,     w_n_d;
    logic [NB_DATA-1:0]  r_b_q,     w_b_d;
    logic                r_tx_q,    w_tx_d;
    logic                r_done_q,  w_done_d;

    always_comb begin
        w_state_d = r_state_q;
        w_s_d     = r_s_q;
        w_n_d     = r_n_q;
        w_b_d     = r_b_q;
        w_done_d  = 1'b0;
        w_tx_d    = 1'b1;
        case (r_state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped; sender re-asserts.
                if (i_tx_start && !r_done_q) begin
                    w_state_d = START;
                    w_s_d     = '0;
                    w_b_d     = i_tx;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_s_q == c_S_LAST) begin
                        w_state_d = DATA;
                        w_s_d     = '0;
                        w_n_d     = '0;
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_s_q == c_S_LAST) begin
                        w_s_d = '0;
                        w_b_d = r_b_q >> 1;
                        if (r_n_q == c_N_LAST) begin
                            w_state_d = STOP;
                        end else begin
                            w_n_d = r_n_q + c_NB_CNT'(1);
                        end
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_s_q == c_S_STOP) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_s_d = r_s_q + 4'd1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
        // Line level follows the state being entered so the output flop stays glitch-free.
        case (w_state_d)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_b_d[0];
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q <= IDLE;
            r_s_q     <= '0;
            r_n_q     <= '0;
            r_b_q     <= '0;
            r_tx_q    <= 1'b1;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_s_q     <= w_s_d;
            r_n_q     <= w_n_d;
            r_b_q     <= w_b_d;
            r_tx_q    <= w_tx_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_tx           = r_tx_q;
    assign o_tx_done_tick = r_done_q;

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_core
//  Brief    : Full-duplex 8N1 UART: shared baud tick, independent rx and tx.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_core
    import uart_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int NB_STATE = 2,
    parameter int BAUD_DIV = c_BAUD_DIV_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_rx_done_tick,
    output logic [NB_DATA-1:0] o_rx
);

    logic w_tick;

    // The 4-bit tick counters cannot represent a stop bit longer than 16 ticks.
    if (NB_STATE != c_NB_STATE || SB_TICK < 1 || SB_TICK > 16) begin : g_bad_params
        $error("uart_core: unsupported NB_STATE or SB_TICK");
    end

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    uart_rx #(
        .NB_DATA (NB_DATA),
        .SB_TICK (SB_TICK)
    ) u_rx (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .i_tick         (w_tick),
        .o_rx_done_tick (o_rx_done_tick),
        .o_rx           (o_rx)
    );

    uart_tx #(
        .NB_DATA (NB_DATA),
        .SB_TICK (SB_TICK)
    ) u_tx (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_tick         (w_tick),
        .i_tx_start     (i_tx_start),
        .i_tx           (i_tx),
        .o_tx           (o_tx),
        .o_tx_done_tick (o_tx_done_tick)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_core
//  Brief    : Self-checking bench for uart_core (loopback, line decode, rx driver).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    localparam int BAUD_DIV = 4;
    localparam int BIT      = 16 * BAUD_DIV;
    localparam int FRAME    = 10 * BIT;
    localparam int BUDGET   = 3 * FRAME;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_drv   = 1'b1;
    logic       loop_en  = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;

    logic       w_tx;
    logic       w_tx_done;
    logic       w_rx_done;
    logic [7:0] w_rx_byte;
    logic       w_rx_line;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    int rx_last  = 0;
    int tx_last  = 0;
    logic [7:0] rx_log[$];

    assign w_rx_line = loop_en ? w_tx : rx_drv;

    uart_core #(
        .NB_DATA  (8),
        .SB_TICK  (16),
        .NB_STATE (2),
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx           (w_rx_line),
        .i_tx_start     (tx_start),
        .i_tx           (tx_data),
        .o_tx           (w_tx),
        .o_tx_done_tick (w_tx_done),
        .o_rx_done_tick (w_rx_done),
        .o_rx           (w_rx_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_rx_done === 1'b1) begin
            rx_log.push_back(w_rx_byte);
            rx_cnt++;
            rx_last = cyc;
        end
        if (w_tx_done === 1'b1) begin
            tx_cnt++;
            tx_last = cyc;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_start(input logic [7:0] b);
        step(1);
        tx_data  = b;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b);
        rx_drv = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            step(BIT);
        end
        rx_drv = 1'b1;
        step(BIT);
    endtask

    task automatic wait_rx(input int target, input string name);
        int k = 0;
        while (rx_cnt < target && k < BUDGET) begin
            step(1);
            k++;
        end
        n_checks++;
        if (rx_cnt < target) begin
            n_fail++;
            $display("FAIL %s: rx done count %0d, required %0d (timeout)", name, rx_cnt, target);
        end
    endtask

    task automatic wait_tx(input int target, input string name);
        int k = 0;
        while (tx_cnt < target && k < BUDGET) begin
            step(1);
            k++;
        end
        n_checks++;
        if (tx_cnt < target) begin
            n_fail++;
            $display("FAIL %s: tx done count %0d, required %0d (timeout)", name, tx_cnt, target);
        end
    endtask

    // Independent line decoder: finds the start edge and samples near each bit middle.
    task automatic capture_tx(output logic [7:0] b, output logic stop_ok, output logic found);
        int k = 0;
        b       = 8'h00;
        stop_ok = 1'b0;
        while (k < BUDGET && w_tx !== 1'b0) begin
            step(1);
            k++;
        end
        found = (w_tx === 1'b0);
        if (found) begin
            step(BIT + BIT / 2 - 2);
            for (int i = 0; i < 8; i++) begin
                b[i] = w_tx;
                step(BIT);
            end
            stop_ok = (w_tx === 1'b1);
        end
    endtask

    task automatic wait_level(input logic lvl, output int t);
        int k = 0;
        while (k < BUDGET && w_tx !== lvl) begin
            step(1);
            k++;
        end
        t = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++;
        if (w_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1", w_tx); end
        n_checks++;
        if (w_rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h, expected 00", w_rx_byte); end
        n_checks++;
        if (w_tx_done !== 1'b0 || w_rx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got tx=%b rx=%b, expected 0/0", w_tx_done, w_rx_done);
        end
        rst = 1'b0;
        step(2 * BIT);
        n_checks++;
        if (w_tx !== 1'b1 || rx_cnt != 0 || tx_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: tx=%b rx_cnt=%0d tx_cnt=%0d, expected 1/0/0", w_tx, rx_cnt, tx_cnt);
        end
    endtask

    task automatic test_single();
        logic [7:0] cap;
        logic       stop_ok;
        logic       found;
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        int t_start = 0;
        loop_en = 1'b1;
        rx_log.delete();
        fork
            begin send_start(8'hE5); t_start = cyc; end
            capture_tx(cap, stop_ok, found);
        join
        wait_rx(rx0 + 1, "single_rx");
        wait_tx(tx0 + 1, "single_tx");
        step(BIT);
        n_checks++;
        if (!found || cap !== 8'hE5) begin n_fail++; $display("FAIL single_line: got %h, expected e5", cap); end
        n_checks++;
        if (stop_ok !== 1'b1) begin n_fail++; $display("FAIL single_stop: got %b, expected 1", stop_ok); end
        n_checks++;
        if (w_rx_byte !== 8'hE5) begin n_fail++; $display("FAIL single_rx_byte: got %h, expected e5", w_rx_byte); end
        n_checks++;
        if (rx_cnt - rx0 != 1 || tx_cnt - tx0 != 1) begin
            n_fail++;
            $display("FAIL single_pulses: rx=%0d tx=%0d, expected 1/1", rx_cnt - rx0, tx_cnt - tx0);
        end
        n_checks++;
        if (tx_last - rx_last < 1 || tx_last - rx_last > BIT) begin
            n_fail++;
            $display("FAIL single_done_order: tx-rx gap %0d, expected 1..%0d", tx_last - rx_last, BIT);
        end
        n_checks++;
        if (tx_last - t_start < 159 * BAUD_DIV || tx_last - t_start > 160 * BAUD_DIV + 1) begin
            n_fail++;
            $display("FAIL single_frame_len: got %0d cycles, expected %0d..%0d",
                     tx_last - t_start, 159 * BAUD_DIV, 160 * BAUD_DIV + 1);
        end
    endtask

    task automatic test_bit_period();
        int t0, t1, t2, t3;
        int tx0 = tx_cnt;
        int rx0 = rx_cnt;
        loop_en = 1'b1;
        send_start(8'h55);
        n_checks++;
        if (w_tx !== 1'b0) begin n_fail++; $display("FAIL start_edge: got %b, expected 0", w_tx); end
        t0 = cyc;
        wait_level(1'b1, t1);
        wait_level(1'b0, t2);
        wait_level(1'b1, t3);
        n_checks++;
        if (t1 - t0 < BIT - BAUD_DIV + 1 || t1 - t0 > BIT) begin
            n_fail++;
            $display("FAIL start_bit_len: got %0d, expected %0d..%0d", t1 - t0, BIT - BAUD_DIV + 1, BIT);
        end
        n_checks++;
        if (t2 - t1 != BIT) begin n_fail++; $display("FAIL bit0_len: got %0d, expected %0d", t2 - t1, BIT); end
        n_checks++;
        if (t3 - t2 != BIT) begin n_fail++; $display("FAIL bit1_len: got %0d, expected %0d", t3 - t2, BIT); end
        wait_tx(tx0 + 1, "period_tx");
        wait_rx(rx0 + 1, "period_rx");
        n_checks++;
        if (w_rx_byte !== 8'h55) begin n_fail++; $display("FAIL period_rx_byte: got %h, expected 55", w_rx_byte); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[$];
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        seq = '{8'h00, 8'hFF, 8'hA5};
        for (int i = 0; i < 3; i++) seq.push_back(8'($urandom));
        loop_en = 1'b1;
        rx_log.delete();
        send_start(seq[0]);
        for (int i = 1; i < seq.size(); i++) begin
            wait_tx(tx0 + i, "b2b_tx");
            send_start(seq[i]);
        end
        wait_tx(tx0 + seq.size(), "b2b_tx_last");
        wait_rx(rx0 + seq.size(), "b2b_rx_last");
        step(BIT);
        n_checks++;
        if (rx_log.size() != seq.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, expected %0d", rx_log.size(), seq.size());
        end
        for (int i = 0; i < seq.size() && i < rx_log.size(); i++) begin
            n_checks++;
            if (rx_log[i] !== seq[i]) begin
                n_fail++;
                $display("FAIL b2b_byte[%0d]: got %h, expected %h", i, rx_log[i], seq[i]);
            end
        end
    endtask

    task automatic test_done_collision();
        logic [7:0] b1 = 8'($urandom);
        logic [7:0] b2 = ~b1;
        logic       low_seen = 1'b0;
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        loop_en = 1'b1;
        rx_log.delete();
        send_start(b1);
        wait_tx(tx0 + 1, "coll_tx1");
        tx_data  = b2;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (w_tx !== 1'b1) low_seen = 1'b1;
            step(1);
        end
        n_checks++;
        if (low_seen || tx_cnt != tx0 + 1) begin
            n_fail++;
            $display("FAIL coll_ignored: line_low=%b tx_cnt=%0d, expected 0/%0d", low_seen, tx_cnt, tx0 + 1);
        end
        send_start(b2);
        wait_rx(rx0 + 2, "coll_rx");
        wait_tx(tx0 + 2, "coll_tx2");
        n_checks++;
        if (rx_log.size() != 2 || rx_log[0] !== b1 || rx_log[1] !== b2) begin
            n_fail++;
            $display("FAIL coll_bytes: got %0d bytes last %h, expected %h then %h",
                     rx_log.size(), w_rx_byte, b1, b2);
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] b1 = 8'($urandom);
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        loop_en = 1'b1;
        send_start(b1);
        step(5 * BIT);
        tx_data  = ~b1;
        tx_start = 1'b1;
        step(1);
        tx_start = 1'b0;
        tx_data  = b1 ^ 8'h3C;
        wait_rx(rx0 + 1, "ign_rx");
        wait_tx(tx0 + 1, "ign_tx");
        step(3 * BIT);
        n_checks++;
        if (rx_cnt - rx0 != 1 || tx_cnt - tx0 != 1) begin
            n_fail++;
            $display("FAIL ign_pulses: rx=%0d tx=%0d, expected 1/1", rx_cnt - rx0, tx_cnt - tx0);
        end
        n_checks++;
        if (w_rx_byte !== b1) begin n_fail++; $display("FAIL ign_byte: got %h, expected %h", w_rx_byte, b1); end
        n_checks++;
        if (w_tx !== 1'b1) begin n_fail++; $display("FAIL ign_line_idle: got %b, expected 1", w_tx); end
    endtask

    task automatic test_glitch();
        logic [7:0] b = 8'($urandom);
        int rx0;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        step(4);
        rx0 = rx_cnt;
        rx_drv = 1'b0;
        step(3 * BAUD_DIV);
        rx_drv = 1'b1;
        step(2 * FRAME);
        n_checks++;
        if (rx_cnt != rx0) begin n_fail++; $display("FAIL glitch_reject: got %0d pulses, expected 0", rx_cnt - rx0); end
        drive_frame(8'h3C);
        wait_rx(rx0 + 1, "glitch_frame_rx");
        n_checks++;
        if (w_rx_byte !== 8'h3C) begin n_fail++; $display("FAIL glitch_frame: got %h, expected 3c", w_rx_byte); end
        drive_frame(b);
        wait_rx(rx0 + 2, "drv_frame_rx");
        n_checks++;
        if (w_rx_byte !== b) begin n_fail++; $display("FAIL drv_frame: got %h, expected %h", w_rx_byte, b); end
        loop_en = 1'b1;
        step(BIT);
    endtask

    task automatic test_reset_mid();
        logic [7:0] cap;
        logic       stop_ok;
        logic       found;
        int rx0 = rx_cnt;
        int tx0 = tx_cnt;
        loop_en = 1'b1;
        send_start(8'($urandom) | 8'h81);
        step(4 * BIT);
        rst = 1'b1;
        step(1);
        n_checks++;
        if (w_tx !== 1'b1 || w_tx_done !== 1'b0 || w_rx_done !== 1'b0 || w_rx_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: tx=%b txd=%b rxd=%b rx=%h, expected 1/0/0/00",
                     w_tx, w_tx_done, w_rx_done, w_rx_byte);
        end
        rst = 1'b0;
        step(2 * FRAME);
        n_checks++;
        if (rx_cnt != rx0 || tx_cnt != tx0) begin
            n_fail++;
            $display("FAIL midreset_no_done: rx=%0d tx=%0d, expected 0/0", rx_cnt - rx0, tx_cnt - tx0);
        end
        fork
            send_start(8'h5A);
            capture_tx(cap, stop_ok, found);
        join
        wait_rx(rx0 + 1, "midreset_rx");
        wait_tx(tx0 + 1, "midreset_tx");
        n_checks++;
        if (w_rx_byte !== 8'h5A || !found || cap !== 8'h5A || !stop_ok) begin
            n_fail++;
            $display("FAIL midreset_resume: rx=%h line=%h, expected 5a/5a", w_rx_byte, cap);
        end
    endtask

    task automatic test_random_loopback();
        loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b = 8'($urandom);
            int rx0 = rx_cnt;
            int tx0 = tx_cnt;
            step($urandom_range(1, 2 * BIT));
            send_start(b);
            wait_rx(rx0 + 1, "rand_rx");
            wait_tx(tx0 + 1, "rand_tx");
            n_checks++;
            if (w_rx_byte !== b) begin
                n_fail++;
                $display("FAIL rand_byte[%0d]: got %h, expected %h", i, w_rx_byte, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bit_period();
        test_back_to_back();
        test_done_collision();
        test_ignore_start();
        test_glitch();
        test_reset_mid();
        test_random_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_core.md
# uart_core

Full-duplex 8N1 UART core (module `uart_core`) with an internal baud-tick generator, one receiver FSM and one transmitter FSM sharing that tick. It sits between the board pins and the byte-level logic (e.g. an ALU/command interface). It exposes a one-cycle start strobe on the transmit side and one-cycle done strobes on both sides. Loopback of `o_tx` into `i_rx` returns every transmitted byte unchanged.

## Interface
- `NB_DATA`, 8: data bits per frame.
- `SB_TICK`, 16: baud ticks per stop bit (16 = 1 stop bit).
- `NB_STATE`, 2: state register width (4 states).
- `BAUD_DIV`, 326: clock cycles per oversampling tick (50 MHz / (9600 × 16) ≈ 326).
- `i_clk`  in  1  system clock, 50 MHz nominal.
- `i_reset`  in  1  reset; one clock, reset is synchronous and active-high.
- `i_rx`  in  1  serial input, idle high.
- `i_tx_start`  in  1  request to send `i_tx`.
- `i_tx`  in  NB_DATA  byte to send, sampled when the start is accepted.
- `o_tx`  out  1  serial output, idle high.
- `o_tx_done_tick`  out  1  one-cycle pulse at end of transmitted stop bit.
- `o_rx_done_tick`  out  1  one-cycle pulse when a received byte is valid.
- `o_rx`  out  NB_DATA  last received byte.

## Operation
- Tick generator: counter 0..BAUD_DIV-1 that wraps. `tick` is high for one cycle when the counter equals BAUD_DIV-1. The counter free-runs and is not aligned to frames.
- Frame format: start bit (0), NB_DATA data bits LSB first, stop bit (1). No parity. Each bit lasts 16 ticks; the stop bit lasts SB_TICK ticks.
- Rx synchronizer: `i_rx` passes through a 2-flop synchronizer (reset to 1). All rx logic uses the synchronized value.
- Rx FSM states:
  - IDLE: a low line → START, tick count s=0.
  - START: on tick, if s==7 (mid start bit): line still low → DATA with s=0, n=0; line high → IDLE (glitch reject). Otherwise s++.
  - DATA: on tick, if s==15, shift the line into the MSB of the shift register (right shift) and set s=0. After the NB_DATA-th sample go to STOP; otherwise n++. Otherwise s++.
  - STOP: on tick, if s==SB_TICK-1, load `o_rx` from the shift register, pulse `o_rx_done_tick` and go to IDLE. Otherwise s++.
  - The stop-bit value is not checked; no framing-error output.
- Tx FSM states:
  - IDLE: `o_tx`=1. When `i_tx_start`=1, latch `i_tx`, go to START, s=0.
  - START: `o_tx`=0 for 16 ticks.
  - DATA: `o_tx` = shift-register bit 0 for 16 ticks per bit; shift right after each bit. After NB_DATA bits go to STOP.
  - STOP: `o_tx`=1 for SB_TICK ticks, then pulse `o_tx_done_tick` and go to IDLE.
- `i_tx_start` is ignored outside IDLE, and later changes to `i_tx` during a frame have no effect.
- `o_tx` is registered and glitch-free.
- `o_rx` holds its value until the next completed reception.

## Timing
- Reset values: `o_tx`=1, `o_tx_done_tick`=0, `o_rx_done_tick`=0, `o_rx`=0. Both FSMs go to IDLE, all counters and shift registers to 0, tick counter to 0.
- Reset mid-frame aborts the frame immediately; no done pulse is issued.
- `o_tx` falls on the clock edge after `i_tx_start` is sampled high in IDLE. The first start bit may be up to one tick short because the tick counter is free-running.
- Frame duration ≈ (10 × 16) × BAUD_DIV cycles ≈ 1.043 ms at defaults.
- Rx done occurs ≈ 9.5 bit times (≈ 9.5 × 16 × BAUD_DIV cycles) after the start edge on the line.
- A new `i_tx_start` is accepted the cycle after `o_tx_done_tick`.
- If `i_tx_start` arrives on the same cycle as `o_tx_done_tick`, it is not accepted; the sender must re-assert it.
- Rx returns to IDLE on the same cycle as the done pulse and detects a following start bit immediately.
- Rx and tx run fully independently; simultaneous activity is allowed.

## Structure
- Shared package `uart_pkg`:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3 (NB_STATE bits);
  - oversampling constant 16 and mid-bit constant 7;
  - default BAUD_DIV.
- Sub-modules:
  - `uart_baud_gen` (tick generator) is the natural sub-module;
  - `uart_rx` and `uart_tx` are separate instances of one FSM style each, all wired in `uart_core`.
- Counter widths: s is 4 bits (must hold SB_TICK-1); n is $clog2(NB_DATA) bits.

## Test plan
- Loopback (`o_tx`→`i_rx`), reset 10 ns, pulse `i_tx_start` with `i_tx`=8'b11100101 → exactly one `o_rx_done_tick`, `o_rx`=8'hE5, within 1.04 ms; `o_tx_done_tick` follows about half a bit later.
- Loopback, back-to-back bytes 8'h00, 8'hFF, 8'hA5, each started the cycle after `o_tx_done_tick` → three rx done pulses in order with matching values.
- Pulse `i_tx_start` mid-frame with a different `i_tx` → ignored; the first byte is received intact and only one tx done pulse occurs.
- Drive `i_rx` low for 3 ticks, then high → no rx done; rx returns to IDLE; a subsequent valid frame 8'h3C is received correctly.
- Assert `i_reset` during the DATA phase → `o_tx`=1 next cycle, no done pulses; a following transmission of 8'h5A completes correctly.
- After reset check `o_tx`=1, `o_rx`=0, both done ticks 0; measure the line bit period = 16 × BAUD_DIV cycles (±1 tick on the start bit).
